// File: rtl/vga_scanout.sv
// VGA timing generator with byte-wide framebuffer fetcher, prefetch FIFO and
// MSB-first pixel unpacker; one clock domain, timing paced by pix_ce.
module vga_scanout #(
    parameter int          HLEN       = 640,
    parameter int          HFP        = 16,
    parameter int          HPULSE     = 96,
    parameter int          HBP        = 48,
    parameter int          VLEN       = 480,
    parameter int          VFP        = 10,
    parameter int          VPULSE     = 2,
    parameter int          VBP        = 33,
    parameter int          BPP        = 4,
    parameter int          FIFO_DEPTH = 16,
    parameter int          ADDR_W     = 20,
    parameter int unsigned BASE       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    output logic              vmem_req,
    output logic [ADDR_W-1:0] vmem_addr,
    input  logic              vmem_ack,
    input  logic [7:0]        vmem_data,
    output logic              hsync,
    output logic              vsync,
    output logic              dataenable,
    output logic [BPP-1:0]    pixel,
    output logic              frame_start,
    output logic              underflow
);
    localparam int HTOT        = HLEN + HFP + HPULSE + HBP;
    localparam int VTOT        = VLEN + VFP + VPULSE + VBP;
    localparam int FRAME_BYTES = HLEN * VLEN * BPP / 8;
    localparam int PPB         = 8 / BPP;
    localparam int HW          = $clog2(HTOT + 1);
    localparam int VW          = $clog2(VTOT + 1);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CW          = AW + 1;

    localparam logic [HW-1:0]     H_VIS     = HW'(HLEN);
    localparam logic [HW-1:0]     H_SS      = HW'(HLEN + HFP);
    localparam logic [HW-1:0]     H_SE      = HW'(HLEN + HFP + HPULSE);
    localparam logic [HW-1:0]     H_LAST    = HW'(HTOT - 1);
    localparam logic [VW-1:0]     V_VIS     = VW'(VLEN);
    localparam logic [VW-1:0]     V_SS      = VW'(VLEN + VFP);
    localparam logic [VW-1:0]     V_SE      = VW'(VLEN + VFP + VPULSE);
    localparam logic [VW-1:0]     V_LAST    = VW'(VTOT - 1);
    localparam logic [CW-1:0]     F_FULL    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     F_HALF    = CW'(FIFO_DEPTH / 2);
    localparam logic [ADDR_W-1:0] A_BASE    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(BASE + FRAME_BYTES - 1);
    localparam logic [3:0]        LEFT_INIT = 4'(PPB - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t          state;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [7:0]      fifo_head;
    logic [7:0]      shreg;
    logic [3:0]      pix_left;

    logic ack_ok, fifo_empty, run_ce, visible;
    logic need_pop, do_pop, starve, fs_evt, resync, do_wr;

    always_comb begin
        fifo_head  = fifo_mem[rd_ptr];
        ack_ok     = vmem_req && vmem_ack;
        fifo_empty = (fifo_cnt == '0);
        run_ce     = (state == RUN) && pix_ce;
        visible    = (hcnt < H_VIS) && (vcnt < V_VIS);
        need_pop   = run_ce && visible && (pix_left == '0);
        do_pop     = need_pop && !fifo_empty;
        starve     = need_pop && fifo_empty;
        fs_evt     = run_ce && (hcnt == '0) && (vcnt == '0);
        resync     = run_ce && underflow && (vcnt == V_VIS) && (hcnt == '0);
        do_wr      = ack_ok && !resync && !rst;
    end

    // Fetcher: a request stays up until acked; a resync abandons it and restarts at BASE.
    always_ff @(posedge clk) begin
        if (rst) begin
            vmem_req  <= 1'b0;
            vmem_addr <= A_BASE;
        end else if (resync) begin
            vmem_req  <= 1'b0;
            vmem_addr <= A_BASE;
        end else if (ack_ok) begin
            vmem_req  <= 1'b0;
            vmem_addr <= (vmem_addr == A_LAST) ? A_BASE : vmem_addr + ADDR_W'(1);
        end else if (!vmem_req && (fifo_cnt < F_FULL)) begin
            vmem_req  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) fifo_mem[wr_ptr] <= vmem_data;
    end

    always_ff @(posedge clk) begin
        if (rst || resync) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!do_wr && do_pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            case (state)
                FILL: if (fifo_cnt >= F_HALF) state <= RUN;
                RUN: if (pix_ce) begin
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Unpacker: the first pixel of a byte comes straight from the FIFO head so there is no bubble.
    always_ff @(posedge clk) begin
        if (rst || resync) begin
            shreg    <= '0;
            pix_left <= '0;
        end else if (do_pop) begin
            shreg    <= fifo_head << BPP;
            pix_left <= LEFT_INIT;
        end else if (run_ce && visible && (pix_left != '0)) begin
            shreg    <= shreg << BPP;
            pix_left <= pix_left - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel       <= '0;
            dataenable  <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            frame_start <= fs_evt;
            if (fs_evt)      underflow <= starve;
            else if (starve) underflow <= 1'b1;
            if (run_ce) begin
                dataenable <= visible;
                hsync      <= !((hcnt >= H_SS) && (hcnt < H_SE));
                vsync      <= !((vcnt >= V_SS) && (vcnt < V_SE));
                if (!visible || starve)  pixel <= '0;
                else if (pix_left == '0) pixel <= fifo_head[7 -: BPP];
                else                     pixel <= shreg[7 -: BPP];
            end
        end
    end
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameter HLEN, default 640, visible pixels per line.
REQ-002 SHALL have parameters HFP/HPULSE/HBP, defaults 16/96/48, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters VLEN/VFP/VPULSE/VBP, defaults 480/10/2/33, the vertical equivalents in lines.
REQ-004 SHALL have parameter BPP, default 4, bits per pixel; legal values 1, 2, 4, 8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries; a power of two, at least 4.
REQ-006 SHALL have parameters ADDR_W, default 20, address width, and BASE, default 0, framebuffer byte base address.
REQ-007 SHALL have clock and reset ports: clk, input, 1, the single clock; rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have pix_ce, input, 1, pixel-clock enable; timing advances only on cycles where it is high.
REQ-009 SHALL have vmem_req, output, 1, read request; vmem_addr, output, ADDR_W, byte address.
REQ-010 SHALL have vmem_ack, input, 1, read done; vmem_data, input, 8, data valid in the ack cycle.
REQ-011 SHALL have hsync and vsync, output, 1 each, active-low syncs; dataenable, output, 1, visible area.
REQ-012 SHALL have pixel, output, BPP, pixel value; 0 outside the visible area.
REQ-013 SHALL have frame_start, output, 1, one-cycle pulse; underflow, output, 1, sticky error flag.

Function
REQ-014 FRAME_BYTES SHALL equal HLEN*VLEN*BPP/8; HTOT SHALL equal HLEN+HFP+HPULSE+HBP; VTOT SHALL equal VLEN+VFP+VPULSE+VBP.
REQ-015 Fetcher: SHALL raise vmem_req when FIFO free entries exceed 0, with at most one request outstanding.
REQ-016 Fetcher: SHALL hold vmem_addr and vmem_req stable until vmem_ack.
REQ-017 Fetcher: SHALL write vmem_data into the FIFO in the ack cycle and drop req for at least that cycle.
REQ-018 Fetcher: address SHALL increment by 1 after each ack and wrap from BASE+FRAME_BYTES-1 to BASE.
REQ-019 FIFO occupancy SHALL never exceed FIFO_DEPTH; a write and a read in the same cycle SHALL leave occupancy unchanged.
REQ-020 Start-up: counters hcnt/vcnt SHALL stay at 0 (state FILL) until occupancy is at least FIFO_DEPTH/2, then enter state RUN.
REQ-021 In RUN, on each pix_ce, hcnt SHALL increment and wrap at HTOT-1 to 0; vcnt SHALL increment on hcnt wrap and wrap at VTOT-1 to 0.
REQ-022 visible SHALL be (hcnt<HLEN)&&(vcnt<VLEN).
REQ-023 hsync SHALL be low for HLEN+HFP <= hcnt < HLEN+HFP+HPULSE.
REQ-024 vsync SHALL be low for VLEN+VFP <= vcnt < VLEN+VFP+VPULSE.
REQ-025 Unpack: on a visible pix_ce, SHALL emit the next BPP bits MSB-first from the current byte.
REQ-026 Unpack: SHALL pop a new FIFO byte when the current byte is exhausted, giving 8/BPP pixels per byte with no bubble.
REQ-027 Outputs pixel/hsync/vsync/dataenable SHALL be registered, updated only on pix_ce, all with one pix_ce latency from counter state.
REQ-028 frame_start SHALL pulse for one clk on the pix_ce where hcnt=0 and vcnt=0 in RUN.
REQ-029 Underflow: if a pop is needed while the FIFO is empty, pixel SHALL be 0 for that pixel, underflow SHALL set, and the pop SHALL be skipped.
REQ-030 Underflow SHALL stay set until the next frame_start.
REQ-031 Resync: if underflow is set when vcnt reaches VLEN with hcnt=0, the FIFO and unpacker SHALL flush, an in-flight ack SHALL be discarded, and the next request SHALL use BASE.
REQ-032 pix_ce low SHALL freeze counters, unpacker and outputs; the fetcher SHALL keep running.

Reset
REQ-033 While rst is high, at each clk edge: state=FILL, hcnt=vcnt=0, FIFO empty, vmem_req=0, vmem_addr=BASE, pixel=0, dataenable=0, hsync=vsync=1, frame_start=0, underflow=0.
REQ-034 Reset mid-request SHALL abandon the transaction; an ack arriving during or after reset SHALL be ignored.

Verification
REQ-035 Params HLEN=8 HFP=1 HPULSE=2 HBP=1 VLEN=2 VFP=1 VPULSE=1 VBP=1 BPP=4, ack 1 cycle after req, pix_ce=1 -> bytes 0x12,0x34... give pixels 1,2,3,4...; hsync low for exactly 2 pix_ce per line; frame_start once per 60 pix_ce.
REQ-036 BPP=1, byte 0xA5 -> pixels 1,0,1,0,0,1,0,1 on consecutive pix_ce.
REQ-037 Ack latency 3 cycles, pix_ce every cycle, BPP=8 -> underflow set within the first line, pixel=0 on starved pixels, address resets to BASE at vblank, next frame clean (underflow cleared at frame_start).
REQ-038 Address wrap: BASE=0x100, FRAME_BYTES=8 -> request sequence 0x100..0x107,0x100.
REQ-039 pix_ce 1-in-4, random ack delay 0-2 -> no underflow, FIFO never exceeds FIFO_DEPTH, outputs change only after pix_ce cycles.
REQ-040 rst asserted mid-line with req pending, late ack delivered -> all REQ-033 values next cycle, no FIFO write, FILL re-entered.
